bloco_controle_polinomio: RTL
=============================

Name: bloco_controle_polinomio

Overview:
Control unit (FSM) directly upstream of the polynomial datapath. It drives the datapath mux selects, register load enables and the ALU operation select to evaluate y = A*x^2 + B*x + C as a fixed micro-sequence. It provides a start/done handshake to the system.
- Datapath semantics:
  - R0 holds x.
  - R1 and R2 hold intermediate results.
  - M0 selects 0/A/B/C.
  - M1 selects M0out/R0/R1/R2.
  - M2 selects R0/M0out/R1/R2.
  - H=1 selects multiply; H=0 selects add.

Parameters:
- ULA_LAT, 0, extra clock cycles the ALU needs before its result is valid (0..7).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- inicio  input  1  start request, level-sampled in IDLE.
- cancela  input  1  synchronous abort, returns to IDLE.
- M0  output  2  datapath mux 0 select.
- M1  output  2  datapath mux 1 select.
- M2  output  2  datapath mux 2 select.
- LX  output  1  load enable, x register (R0).
- LH  output  1  load enable, R1.
- LS  output  1  load enable, R2 (result).
- H  output  1  ALU op: 1 = multiply, 0 = add.
- ocupado  output  1  high in every state except IDLE.
- pronto  output  1  one-cycle pulse; R2 holds y.

Behaviour:
- Reset (async, rst=1): state=IDLE, latency counter=0. All outputs 0 (M0=M1=M2=0, LX=LH=LS=H=0, ocupado=0, pronto=0). Effect is immediate, including mid-sequence.
- Moore machine: outputs decode only from state and latency counter; no combinational path from inicio or cancela to outputs.
- States and control vectors (M0,M1,M2,H; enable):
  - IDLE: all 0; stays until inicio=1 at a rising edge, then goes to CARGA.
  - CARGA: LX=1, others 0; 1 cycle; goes to QUAD.
  - QUAD: M0=0, M1=1, M2=0, H=1; LH on final cycle (R1=x*x).
  - AX2: M0=1, M1=0, M2=2, H=1; LS on final cycle (R2=A*x^2).
  - BX: M0=2, M1=0, M2=0, H=1; LH on final cycle (R1=B*x).
  - SOMA1: M0=0, M1=2, M2=3, H=0; LS on final cycle (R2=R2+R1).
  - SOMAC: M0=3, M1=0, M2=3, H=0; LS on final cycle (R2=R2+C).
  - FIM: pronto=1, ocupado=1, all enables 0; 1 cycle; goes to IDLE.
- Compute states QUAD..SOMAC each last 1+ULA_LAT cycles:
  - Selects and H are held constant for the whole state.
  - The load enable is asserted only on the last cycle (counter==ULA_LAT).
  - The counter clears on every state change.
- Latency: start accepted at edge k; pronto high during cycle k+7+5*ULA_LAT (7 for ULA_LAT=0). Total ocupado duration is 7+5*ULA_LAT cycles.
- inicio is ignored while ocupado=1. inicio held high through FIM causes a back-to-back run: IDLE for exactly 1 cycle, then CARGA.
- cancela=1 at an edge in any non-IDLE state:
  - Next state is IDLE with all outputs 0; no pronto is issued.
  - cancela has priority over normal transitions, including in FIM.
  - cancela in IDLE has priority over inicio (stays IDLE).
- Only one load enable is high in any cycle. LX is never high outside CARGA.
- Unreachable state encodings go to IDLE on the next edge.

Test Plan:
- Reset/idle: rst pulse mid-AX2 → all outputs 0 immediately (asynchronously), ocupado=0; with inicio=0 the outputs stay 0 for 10 cycles.
- Nominal run, ULA_LAT=0, paired with a behavioural datapath model, x=2, A=3, B=2, C=5:
  - Control vectors match the state table cycle by cycle.
  - pronto rises exactly 7 cycles after start acceptance.
  - R2=21.
- Latency parameter, ULA_LAT=2, x=3, A=1, B=0, C=4:
  - Each compute state lasts 3 cycles, with its enable only on the third.
  - pronto arrives 17 cycles after start acceptance; R2=13.
- Abort: cancela=1 in the second cycle of BX → next cycle IDLE, all outputs 0, no pronto; a new inicio afterwards completes normally.
- Handshake corners:
  - inicio pulsed during SOMA1 → ignored; exactly one pronto.
  - inicio held high continuously → pronto every 8 cycles (ULA_LAT=0).
  - inicio=1 and cancela=1 together in IDLE → stays IDLE.
- Exclusivity check: assertion across all runs that at most one of LX/LH/LS is high per cycle and pronto is never high for two consecutive cycles.

Source files
------------

// File: rtl/bloco_controle_polinomio_if.sv
// Handshake and control bundle between the system, the polynomial control
// unit and the polynomial datapath.
//   inicio   : start request (system -> controller)
//   cancela  : synchronous abort (system -> controller)
//   M0,M1,M2 : datapath mux selects (controller -> datapath)
//   LX,LH,LS : load enables for R0, R1, R2 (controller -> datapath)
//   H        : ALU op, 1 = multiply, 0 = add (controller -> datapath)
//   ocupado  : busy, high outside IDLE (controller -> system)
//   pronto   : one-cycle done pulse, R2 holds y (controller -> system)
interface bloco_controle_polinomio_if;
    logic       inicio;
    logic       cancela;
    logic [1:0] M0;
    logic [1:0] M1;
    logic [1:0] M2;
    logic       LX;
    logic       LH;
    logic       LS;
    logic       H;
    logic       ocupado;
    logic       pronto;

    // System / environment side
    modport master (
        output inicio, cancela,
        input  M0, M1, M2, LX, LH, LS, H, ocupado, pronto
    );

    // Control unit side
    modport slave (
        input  inicio, cancela,
        output M0, M1, M2, LX, LH, LS, H, ocupado, pronto
    );
endinterface

// File: rtl/bloco_controle_polinomio.sv
// Control unit for the polynomial datapath: sequences y = A*x^2 + B*x + C as
// CARGA, QUAD, AX2, BX, SOMA1, SOMAC, FIM. Each compute state lasts
// 1+ULA_LAT cycles with its load enable only on the final cycle.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : control bundle (slave side), see bloco_controle_polinomio_if
// Outputs are pure Moore decodes of state and latency counter.
module bloco_controle_polinomio #(
    parameter int unsigned ULA_LAT = 0
) (
    input logic                         clk,
    input logic                         rst,
    bloco_controle_polinomio_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CARGA = 3'd1,
        QUAD  = 3'd2,
        AX2   = 3'd3,
        BX    = 3'd4,
        SOMA1 = 3'd5,
        SOMAC = 3'd6,
        FIM   = 3'd7
    } estado_t;

    localparam logic [2:0] LAT = 3'(ULA_LAT);

    estado_t    state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       ultimo;

    logic [1:0] m0, m1, m2;
    logic       lx, lh, ls, h, ocupado, pronto;

    // Final cycle of a compute state; >= keeps the FSM moving even if the
    // counter were ever disturbed past the limit.
    assign ultimo = (cnt_q >= LAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state. The counter only advances while a compute state is still
    // waiting for the ALU; any state change clears it.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (bus.cancela && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (bus.inicio && !bus.cancela) state_d = CARGA;
                CARGA: state_d = QUAD;
                QUAD:  if (ultimo) state_d = AX2;   else cnt_d = cnt_q + 3'd1;
                AX2:   if (ultimo) state_d = BX;    else cnt_d = cnt_q + 3'd1;
                BX:    if (ultimo) state_d = SOMA1; else cnt_d = cnt_q + 3'd1;
                SOMA1: if (ultimo) state_d = SOMAC; else cnt_d = cnt_q + 3'd1;
                SOMAC: if (ultimo) state_d = FIM;   else cnt_d = cnt_q + 3'd1;
                FIM:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Control vectors per state (M0,M1,M2,H held for the whole state).
    always_comb begin
        m0      = '0;
        m1      = '0;
        m2      = '0;
        lx      = 1'b0;
        lh      = 1'b0;
        ls      = 1'b0;
        h       = 1'b0;
        ocupado = 1'b0;
        pronto  = 1'b0;
        case (state_q)
            IDLE: ;
            CARGA: begin
                lx      = 1'b1;
                ocupado = 1'b1;
            end
            QUAD: begin        // R1 = x*x
                m1      = 2'd1;
                h       = 1'b1;
                lh      = ultimo;
                ocupado = 1'b1;
            end
            AX2: begin         // R2 = A*R1
                m0      = 2'd1;
                m2      = 2'd2;
                h       = 1'b1;
                ls      = ultimo;
                ocupado = 1'b1;
            end
            BX: begin          // R1 = B*x
                m0      = 2'd2;
                h       = 1'b1;
                lh      = ultimo;
                ocupado = 1'b1;
            end
            SOMA1: begin       // R2 = R1 + R2
                m1      = 2'd2;
                m2      = 2'd3;
                ls      = ultimo;
                ocupado = 1'b1;
            end
            SOMAC: begin       // R2 = C + R2
                m0      = 2'd3;
                m2      = 2'd3;
                ls      = ultimo;
                ocupado = 1'b1;
            end
            FIM: begin
                pronto  = 1'b1;
                ocupado = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.M0      = m0;
    assign bus.M1      = m1;
    assign bus.M2      = m2;
    assign bus.LX      = lx;
    assign bus.LH      = lh;
    assign bus.LS      = ls;
    assign bus.H       = h;
    assign bus.ocupado = ocupado;
    assign bus.pronto  = pronto;

endmodule
